gpu_fb_scanout_reader: RTL and testbench
========================================

Name: gpu_fb_scanout_reader

Overview:
- Read-side port controller for the dual-port frame-buffer SRAM; the pixel write controller owns the opposite port.
- Each frame, it streams every pixel of the front buffer, the one the write side is not drawing into, out of SRAM in raster order.
- Pixels are pushed into the display pixel FIFO with a valid/full handshake.
- Front-buffer selection tracks the write side's double-buffer toggle (flush) but only changes at frame boundaries, so scan-out never tears.

Parameters:
H_ACTIVE, 640, pixels per line
V_ACTIVE, 480, lines per frame
WIDTH_BITS, 10, x counter width
HEIGHT_BITS, 9, y counter width
CHANNEL_BITS, 8, bits per colour channel
OFFSETMEM, 307200, word offset of buffer 1 (buffer 0 at 0)
READ_WAIT, 2, cycles from address drive to rdata capture (1..7)

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
frame_start  in  1  one-cycle pulse from display timing: begin scanning a frame
flush  in  1  same pulse seen by the write side; toggles write-buffer select
fifo_full  in  1  pixel FIFO cannot accept a word this cycle
sram_rdata  in  3*CHANNEL_BITS  SRAM read data {r,g,b}
sram_addr  out  WIDTH_BITS+HEIGHT_BITS+1  SRAM word address
CE0, CE1, OE, R_W, LB, UB, ZZ, SEM  out  1 each  SRAM port controls
pixel_data  out  3*CHANNEL_BITS  pixel to FIFO
pixel_valid  out  1  pixel_data valid; FIFO write strobe
line_end  out  1  pulses with the last pixel of each line
frame_done  out  1  one-cycle pulse after the last pixel of a frame is pushed
overrun  out  1  one-cycle pulse when frame_start arrives while a frame is still being read

Behaviour:
- Reset state:
  - FSM in IDLE; x=0, y=0, sram_addr=0, pixel_data=0.
  - pixel_valid=line_end=frame_done=overrun=0.
  - wr_sel=0, rd_sel=1.
  - CE0=1, CE1=0, OE=1, R_W=1, LB=1, UB=1, SEM=1, ZZ=0.
- Idle port (all states except ADDR/WAIT, once out of reset): CE0=1, CE1=0, OE=1, R_W=1, LB=UB=1, SEM=1, ZZ=1. R_W is never driven 0 by this block.
- Active read (ADDR, WAIT): CE0=0, CE1=1, OE=0, LB=UB=0, R_W=1.
- Buffer tracking:
  - wr_sel toggles on each flush.
  - On accepted frame_start, rd_sel <= ~wr_sel; if flush is in the same cycle, use the post-toggle value.
  - rd_sel is constant for the rest of the frame.
- Address: sram_addr = y*H_ACTIVE + x + (rd_sel ? OFFSETMEM : 0).
  - Maintain row_base (+= H_ACTIVE per line) rather than using a multiplier.
  - Arithmetic is at full address width; no wrap for legal parameters.
- FSM (registered, transitions on clk):
  - IDLE: on frame_start, go to ADDR; x=y=0; latch rd_sel.
  - ADDR: drive address; wait counter=0; go to WAIT.
  - WAIT: count to READ_WAIT-1, then CAPTURE.
  - CAPTURE: register sram_rdata into a hold register.
    - fifo_full=0: pixel_valid=1 with pixel_data this cycle, then advance.
    - fifo_full=1: go to STALL.
  - STALL: hold pixel_data and the port idle; when fifo_full=0, assert pixel_valid for one cycle, then advance.
  - Advance: if x < H_ACTIVE-1, x++ and go to ADDR. Otherwise x=0 and line_end=1 with that pixel. Then if y < V_ACTIVE-1, y++ and go to ADDR; else go to DONE.
  - DONE: frame_done=1 for one cycle, then IDLE.
- Throughput: READ_WAIT+2 cycles per pixel with no back-pressure; first pixel_valid arrives READ_WAIT+2 cycles after frame_start.
- frame_start outside IDLE (incl. STALL or DONE):
  - overrun=1 that cycle.
  - The current frame is abandoned (no frame_done) and the held pixel is dropped.
  - Restart at ADDR with x=y=0 and freshly latched rd_sel.
- fifo_full is sampled only in CAPTURE/STALL; it never stalls the SRAM access in flight.
- Reset mid-frame returns immediately to the reset state; no further SRAM access.

Test Plan:
- Reset, then frame_start with H_ACTIVE=4, V_ACTIVE=2, READ_WAIT=2, fifo_full=0, SRAM model returning the address as data -> 8 pixel_valid pulses every 4 cycles with data 307200..307207 (rd_sel=1); line_end on pixels 4 and 8; frame_done one cycle after pixel 8.
- flush once, then frame_start -> addresses 0..7 (rd_sel=0). Flush mid-frame -> addresses unchanged until the next frame_start, which then reads the OFFSETMEM buffer.
- Hold fifo_full=1 for 5 cycles at pixel 3 -> pixel_valid suppressed, pixel_data stable, CE0=1 during stall, pixel 3 delivered once after release, no skipped or duplicated addresses.
- frame_start at pixel 5 -> overrun=1 for one cycle, no frame_done, next sram_addr restarts at row 0, col 0 of the newly latched buffer.
- Drop n_rst during WAIT -> CE0=1, OE=1, ZZ=0, pixel_valid=0 asynchronously; after release, FSM stays idle until frame_start.
- Throughout all scenarios: R_W=1 and SEM=1 at all times; CE0/CE1 never both active-low/active-high outside ADDR/WAIT.

Source files
------------

// File: rtl/gpu_fb_scanout_reader.sv
// Frame-buffer scan-out reader: streams the front buffer out of the SRAM read port in raster order.
// Latency: READ_WAIT+2 cycles per pixel; a full FIFO parks the fetched pixel without stalling the SRAM access.
module gpu_fb_scanout_reader #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int OFFSETMEM    = 307200,
  parameter int READ_WAIT    = 2
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                frame_start,
  input  logic                                flush,
  input  logic                                fifo_full,
  input  logic [3*CHANNEL_BITS-1:0]           sram_rdata,
  output logic [WIDTH_BITS+HEIGHT_BITS:0]     sram_addr,
  output logic                                CE0,
  output logic                                CE1,
  output logic                                OE,
  output logic                                R_W,
  output logic                                LB,
  output logic                                UB,
  output logic                                ZZ,
  output logic                                SEM,
  output logic [3*CHANNEL_BITS-1:0]           pixel_data,
  output logic                                pixel_valid,
  output logic                                line_end,
  output logic                                frame_done,
  output logic                                overrun
);

  localparam int AW = WIDTH_BITS + HEIGHT_BITS + 1;
  localparam int DW = 3 * CHANNEL_BITS;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_CAPTURE, S_STALL, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH_BITS-1:0]  x_q, x_d;
  logic [HEIGHT_BITS-1:0] y_q, y_d;
  logic [AW-1:0]          row_base_q, row_base_d;
  logic [AW-1:0]          sram_addr_q, sram_addr_d;
  logic [2:0]             wait_q, wait_d;
  logic [DW-1:0]          pixel_data_q, pixel_data_d;
  logic                   pixel_valid_q, pixel_valid_d;
  logic                   line_end_q, line_end_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;
  logic                   wr_sel_q, wr_sel_d;
  logic                   rd_sel_q, rd_sel_d;
  logic                   port_idle_q, port_idle_d;
  logic                   zz_q, zz_d;
  logic                   push;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    row_base_d    = row_base_q;
    sram_addr_d   = sram_addr_q;
    wait_d        = wait_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    line_end_d    = 1'b0;
    frame_done_d  = 1'b0;
    overrun_d     = 1'b0;
    wr_sel_d      = wr_sel_q ^ flush;
    rd_sel_d      = rd_sel_q;
    zz_d          = 1'b1;
    push          = 1'b0;

    case (state_q)
      S_ADDR: begin
        wait_d  = 3'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Data is sampled on the last wait cycle, while OE is still asserted.
        if (wait_q == 3'(READ_WAIT - 1)) begin
          pixel_data_d = sram_rdata;
          state_d      = S_CAPTURE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_CAPTURE, S_STALL: begin
        if (!fifo_full) begin
          pixel_valid_d = 1'b1;
          push          = 1'b1;
        end else begin
          state_d = S_STALL;
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: ;
    endcase

    if (push) begin
      if (x_q != WIDTH_BITS'(H_ACTIVE - 1)) begin
        x_d         = x_q + WIDTH_BITS'(1);
        sram_addr_d = row_base_q + AW'(x_q) + AW'(1);
        state_d     = S_ADDR;
      end else begin
        x_d        = '0;
        line_end_d = 1'b1;
        if (y_q != HEIGHT_BITS'(V_ACTIVE - 1)) begin
          y_d         = y_q + HEIGHT_BITS'(1);
          row_base_d  = row_base_q + AW'(H_ACTIVE);
          sram_addr_d = row_base_d;
          state_d     = S_ADDR;
        end else begin
          state_d = S_DONE;
        end
      end
    end

    // A new frame always wins: any in-flight or parked pixel is discarded.
    if (frame_start) begin
      overrun_d     = (state_q != S_IDLE);
      rd_sel_d      = ~wr_sel_d;
      x_d           = '0;
      y_d           = '0;
      row_base_d    = rd_sel_d ? AW'(OFFSETMEM) : '0;
      sram_addr_d   = row_base_d;
      pixel_valid_d = 1'b0;
      line_end_d    = 1'b0;
      frame_done_d  = 1'b0;
      state_d       = S_ADDR;
    end

    port_idle_d = !((state_d == S_ADDR) || (state_d == S_WAIT));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      row_base_q    <= '0;
      sram_addr_q   <= '0;
      wait_q        <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      line_end_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b1;
      port_idle_q   <= 1'b1;
      zz_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      row_base_q    <= row_base_d;
      sram_addr_q   <= sram_addr_d;
      wait_q        <= wait_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      line_end_q    <= line_end_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      wr_sel_q      <= wr_sel_d;
      rd_sel_q      <= rd_sel_d;
      port_idle_q   <= port_idle_d;
      zz_q          <= zz_d;
    end
  end

  assign sram_addr   = sram_addr_q;
  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign line_end    = line_end_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign CE0         = port_idle_q;
  assign CE1         = ~port_idle_q;
  assign OE          = port_idle_q;
  assign LB          = port_idle_q;
  assign UB          = port_idle_q;
  assign ZZ          = zz_q;
  assign R_W         = 1'b1;
  assign SEM         = 1'b1;

endmodule

// File: tb/tb_gpu_fb_scanout_reader.sv
// Scoreboard bench for gpu_fb_scanout_reader on a 4x2 frame with a read-only SRAM model.
module tb_gpu_fb_scanout_reader;

  localparam int H   = 4;
  localparam int V   = 2;
  localparam int RW  = 2;
  localparam int OFF = 307200;
  localparam int AW  = 20;
  localparam int DW  = 24;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic frame_start = 1'b0;
  logic flush = 1'b0;
  logic force_full = 1'b0;
  logic rnd_full = 1'b0;
  logic fifo_full;
  logic [DW-1:0] sram_rdata;
  logic [AW-1:0] sram_addr;
  logic CE0, CE1, OE, R_W, LB, UB, ZZ, SEM;
  logic [DW-1:0] pixel_data;
  logic pixel_valid, line_end, frame_done, overrun;

  assign fifo_full = force_full | rnd_full;
  // SRAM returns its address as data, and garbage when the port is not reading.
  assign sram_rdata = (!CE0 && !OE) ? DW'(sram_addr) : 24'hBADBAD;

  gpu_fb_scanout_reader #(
    .H_ACTIVE(H), .V_ACTIVE(V), .WIDTH_BITS(10), .HEIGHT_BITS(9),
    .CHANNEL_BITS(8), .OFFSETMEM(OFF), .READ_WAIT(RW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start), .flush(flush),
    .fifo_full(fifo_full), .sram_rdata(sram_rdata), .sram_addr(sram_addr),
    .CE0(CE0), .CE1(CE1), .OE(OE), .R_W(R_W), .LB(LB), .UB(UB), .ZZ(ZZ), .SEM(SEM),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .line_end(line_end),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            done;
    bit            le;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   pv_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pv = 0;
  int   fs_cyc = 0;
  int   ov_seen = 0;
  int   ov_exp = 0;
  bit   m_wr = 1'b0;
  bit   m_buf = 1'b0;
  bit   rand_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      rnd_full = rand_en && ($urandom_range(0, 2) == 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  // Monitor: port-control invariants every cycle, scoreboard pops on pixel_valid/frame_done.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (!(R_W && SEM && (CE0 != CE1) && (OE == CE0) && (LB == CE0) && (UB == CE0))) begin
      errors++;
      $display("FAIL port_ctrl: R_W=%b SEM=%b CE0=%b CE1=%b OE=%b LB=%b UB=%b", R_W, SEM, CE0, CE1, OE, LB, UB);
    end
    if (overrun) ov_seen++;
    if (pixel_valid) begin
      pv_cyc_q.push_back(cyc);
      last_pv = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected: got data 0x%0h, no pixel expected", pixel_data);
      end else begin
        e = exp_q.pop_front();
        if (e.done || e.dat !== pixel_data || e.le !== line_end) begin
          errors++;
          $display("FAIL pixel: got data 0x%0h le %b, expected done %b data 0x%0h le %b",
                   pixel_data, line_end, e.done, e.dat, e.le);
        end
      end
    end
    if (frame_done) begin
      checks++;
      if (exp_q.size() == 0 || !exp_q[0].done) begin
        errors++;
        $display("FAIL frame_done_unexpected: got frame_done=1, expected no frame_done");
      end else begin
        void'(exp_q.pop_front());
        chk("frame_done_timing", cyc - last_pv, 1);
      end
    end
  end

  // Issues a frame_start; expects npix pixels of the latched buffer (and frame_done if the frame completes).
  task automatic start_frame(input bit fl, input int npix, input bit exp_ov);
    exp_t e;
    int   base;
    @(negedge clk);
    frame_start = 1'b1;
    flush = fl;
    if (fl) m_wr = ~m_wr;
    m_buf = ~m_wr;
    base = m_buf ? OFF : 0;
    for (int i = 0; i < npix; i++) begin
      e.done = 1'b0;
      e.le   = ((i % H) == H - 1);
      e.dat  = DW'(base + i);
      exp_q.push_back(e);
    end
    if (npix == H * V) begin
      e.done = 1'b1;
      e.le   = 1'b0;
      e.dat  = '0;
      exp_q.push_back(e);
    end
    if (exp_ov) ov_exp++;
    @(negedge clk);
    frame_start = 1'b0;
    flush = 1'b0;
    fs_cyc = cyc;
    chk("overrun_pulse", 32'(overrun), 32'(exp_ov));
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    m_wr = ~m_wr;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_left(input int n);
    int t = 0;
    while (exp_q.size() > n && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (exp_q.size() > n) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_timeout: %0d entries outstanding, expected at most %0d", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit idle_ok;
    bit abort;
    bit fl;
    bit pend_ov;
    int k;

    #1 n_rst = 1'b0;
    #2;
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_pixel_data", 32'(pixel_data), 0);
    chk("rst_flags", {28'd0, pixel_valid, line_end, frame_done, overrun}, 0);
    chk("rst_port", {24'd0, CE0, CE1, OE, R_W, LB, UB, SEM, ZZ}, 32'b1011_1110);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_zz", 32'(ZZ), 1);
    chk("idle_ce0", 32'(CE0), 1);

    // Frame A: no flush yet, so buffer 1 is read; also checks latency and pixel rate.
    pv_cyc_q.delete();
    start_frame(1'b0, H * V, 1'b0);
    wait_left(0);
    chk("first_latency", pv_cyc_q[0] - fs_cyc, RW + 2);
    chk("pixel_period", pv_cyc_q[1] - pv_cyc_q[0], RW + 2);
    chk("frame_span", pv_cyc_q[H*V-1] - pv_cyc_q[0], (H * V - 1) * (RW + 2));

    // Flush toggles to buffer 0; a mid-frame flush only takes effect at the next frame.
    pulse_flush();
    start_frame(1'b0, H * V, 1'b0);
    wait_left(0);
    start_frame(1'b0, H * V, 1'b0);
    repeat (6) @(negedge clk);
    pulse_flush();
    wait_left(0);
    start_frame(1'b0, H * V, 1'b0);
    wait_left(0);

    // Back-pressure held across the third pixel.
    start_frame(1'b0, H * V, 1'b0);
    wait_left(H * V + 1 - 2);
    force_full = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      #1;
      chk("stall_ce0", 32'(CE0), 1);
      chk("stall_no_valid", 32'(pixel_valid), 0);
      chk("stall_data", 32'(pixel_data), (m_buf ? OFF : 0) + 2);
    end
    force_full = 1'b0;
    wait_left(0);

    // Abort after pixel 4: overrun, no frame_done, restart from the top of the new buffer.
    start_frame(1'b0, 4, 1'b0);
    wait_left(0);
    start_frame(1'b1, H * V, 1'b1);
    wait_left(0);

    // Randomized frames with random back-pressure, flushes and aborts.
    rand_en = 1'b1;
    pend_ov = 1'b0;
    for (int f = 0; f < 14; f++) begin
      fl = ($urandom_range(0, 3) == 0);
      abort = (f != 13) && ($urandom_range(0, 3) == 0);
      if (abort) begin
        k = $urandom_range(1, H * V - 1);
        start_frame(fl, k, pend_ov);
        pend_ov = 1'b1;
        wait_left(0);
      end else begin
        start_frame(fl, H * V, pend_ov);
        pend_ov = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 30)) @(negedge clk);
          pulse_flush();
        end
        wait_left(0);
      end
    end
    rand_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during WAIT: port goes idle asynchronously, then nothing until frame_start.
    start_frame(1'b0, H * V, 1'b0);
    @(negedge clk);
    #1 n_rst = 1'b0;
    #1;
    chk("arst_ce0", 32'(CE0), 1);
    chk("arst_oe", 32'(OE), 1);
    chk("arst_zz", 32'(ZZ), 0);
    chk("arst_valid", 32'(pixel_valid), 0);
    chk("arst_addr", 32'(sram_addr), 0);
    exp_q.delete();
    m_wr = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    idle_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (!CE0 || pixel_valid || frame_done) idle_ok = 1'b0;
    end
    chk("post_reset_idle", 32'(idle_ok), 1);
    start_frame(1'b0, H * V, 1'b0);
    wait_left(0);

    repeat (5) @(negedge clk);
    chk("overrun_count", ov_seen, ov_exp);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
